// File: rtl/and8_share_arbiter.sv
// rtl/and8_share_arbiter.sv - round-robin arbiter time-sharing one 8-input AND reduction
//
// Purpose:
//   NREQ requesters share a single 8-bit AND-reduction datapath. A round-robin
//   pointer picks one pending request in IDLE and latches its operand. The FSM
//   then walks EVAL (compute) and RESP (hold result/done), giving a fixed
//   throughput of one operation every three cycles under continuous load.
//
// Ports:
//   clk     in   1        system clock, rising edge
//   rst_n   in   1        asynchronous active-low reset
//   req     in   NREQ     level request, bit i = requester i
//   data    in   8*NREQ   operands, requester i drives [8*i+7:8*i]
//   gnt     out  NREQ     one-hot grant, held from grant edge until RESP ends
//   done    out  NREQ     one-cycle pulse to the owner while the result is valid
//   out     out  1        AND of the latched operand, holds between operations
//   out_id  out  IDW      index of the requester that owns out
//   busy    out  1        high in EVAL and RESP

module and8_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] data,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              out,
  output logic [IDW-1:0]    out_id,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [NREQ-1:0] ONE_HOT_0 = {{(NREQ-1){1'b0}}, 1'b1};
  localparam logic [IDW-1:0]  LAST_ID   = IDW'(NREQ-1);

  state_t            state_q;
  logic [IDW-1:0]    ptr_q;
  logic [IDW-1:0]    ptr_d;
  logic [7:0]        opnd_q;
  logic [IDW-1:0]    id_q;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   done_q;
  logic              out_q;
  logic [IDW-1:0]    out_id_q;
  logic              busy_q;

  logic              win_valid;
  logic [IDW-1:0]    win_idx;
  logic [7:0]        win_data;

  // Round-robin search: visit ptr, ptr+1, ... (mod NREQ); first set bit wins.
  always_comb begin
    logic [IDW-1:0] idx;
    win_valid = 1'b0;
    win_idx   = '0;
    idx       = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_valid && req[idx]) begin
        win_valid = 1'b1;
        win_idx   = idx;
      end
      if (idx == LAST_ID) begin
        idx = '0;
      end else begin
        idx = idx + 1'b1;
      end
    end
  end

  // Operand slice of the winner; only consumed on the grant edge.
  assign win_data = data[{win_idx, 3'b000} +: 8];

  // Pointer moves just past the owner so a held request cannot starve others.
  always_comb begin
    ptr_d = '0;
    if (id_q != LAST_ID) begin
      ptr_d = id_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      opnd_q   <= '0;
      id_q     <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      out_q    <= 1'b0;
      out_id_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_valid) begin
            opnd_q  <= win_data;
            id_q    <= win_idx;
            gnt_q   <= ONE_HOT_0 << win_idx;
            busy_q  <= 1'b1;
            state_q <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          out_q    <= &opnd_q;
          out_id_q <= id_q;
          done_q   <= ONE_HOT_0 << id_q;
          state_q  <= ST_RESP;
        end
        ST_RESP: begin
          ptr_q   <= ptr_d;
          done_q  <= '0;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          // Unreachable encoding: drop any ownership and fall back to IDLE.
          gnt_q   <= '0;
          done_q  <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign out    = out_q;
  assign out_id = out_id_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_and8_share_arbiter.sv
// tb/tb_and8_share_arbiter.sv - directed vector bench for and8_share_arbiter
module tb_and8_share_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] data;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              out;
  logic [IDW-1:0]    out_id;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  and8_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .data   (data),
    .gnt    (gnt),
    .done   (done),
    .out    (out),
    .out_id (out_id),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        out;
    logic [1:0]  out_id;
    logic        busy;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // Trace from reset: single request, wrap from ptr=3, zero-bit operand,
    // mid-operation data change + request drop, late request waiting.
    vecs[0]  = '{4'b0000, 32'hFFFFFFFF, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[1]  = '{4'b0100, 32'hFFFFFFFF, 4'b0100, 4'b0000, 1'b0, 2'd0, 1'b1};
    vecs[2]  = '{4'b0000, 32'hFFFFFFFF, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b1};
    vecs[3]  = '{4'b0000, 32'hFFFFFFFF, 4'b0000, 4'b0000, 1'b1, 2'd2, 1'b0};
    vecs[4]  = '{4'b0011, 32'hFFFFFFFE, 4'b0001, 4'b0000, 1'b1, 2'd2, 1'b1};
    vecs[5]  = '{4'b0011, 32'hFFFFFFFE, 4'b0001, 4'b0001, 1'b0, 2'd0, 1'b1};
    vecs[6]  = '{4'b0011, 32'hFFFFFFFE, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[7]  = '{4'b0011, 32'hFFFFFFFF, 4'b0010, 4'b0000, 1'b0, 2'd0, 1'b1};
    vecs[8]  = '{4'b0001, 32'hFFFF00FF, 4'b0010, 4'b0010, 1'b1, 2'd1, 1'b1};
    vecs[9]  = '{4'b0001, 32'hFFFF00FF, 4'b0000, 4'b0000, 1'b1, 2'd1, 1'b0};
    vecs[10] = '{4'b0001, 32'hFFFF00FF, 4'b0001, 4'b0000, 1'b1, 2'd1, 1'b1};
    vecs[11] = '{4'b0000, 32'hFFFF00FF, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b1};
    vecs[12] = '{4'b0000, 32'hFFFF00FF, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b0};

    // Reset with inputs active.
    rst_n = 1'b0;
    req   = 4'b1111;
    data  = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    #1;
    check("reset_gnt", 32'(gnt), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_out", 32'(out), 32'h0);
    check("reset_out_id", 32'(out_id), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      req  = vecs[i].req;
      data = vecs[i].data;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].done));
      check($sformatf("vec%0d_out", i), 32'(out), 32'(vecs[i].out));
      check($sformatf("vec%0d_out_id", i), 32'(out_id), 32'(vecs[i].out_id));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
    end

    // Round-robin under full load from ptr=0: order 0,1,2,3,0.
    rst_n = 1'b0;
    req   = 4'b1111;
    data  = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      logic [3:0] exp_oh;
      int ph;
      ph     = (c - 1) % 3;
      exp_oh = 4'b0001 << (((c - 1) / 3) % 4);
      @(posedge clk);
      #1;
      check($sformatf("rr%0d_gnt", c), 32'(gnt), (ph < 2) ? 32'(exp_oh) : 32'h0);
      check($sformatf("rr%0d_done", c), 32'(done), (ph == 1) ? 32'(exp_oh) : 32'h0);
      check($sformatf("rr%0d_busy", c), 32'(busy), (ph < 2) ? 32'h1 : 32'h0);
      check($sformatf("rr%0d_onehot0", c), 32'($onehot0(gnt)), 32'h1);
    end

    // Reset in the middle of EVAL: abort, no done, pointer back to 0.
    req = 4'b0001;
    @(posedge clk);
    #1;
    check("abort_pre_gnt", 32'(gnt), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_gnt", 32'(gnt), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_out", 32'(out), 32'h0);
    @(posedge clk);
    #1;
    check("abort_hold_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    req   = 4'b0011;
    @(posedge clk);
    #1;
    check("post_reset_gnt", 32'(gnt), 32'h1);
    check("post_reset_done", 32'(done), 32'h0);
    @(posedge clk);
    #1;
    check("post_reset_done2", 32'(done), 32'h1);
    check("post_reset_out", 32'(out), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/and8_share_arbiter.md
Name: and8_share_arbiter

Overview:
- Time-shares one 8-input AND-reduction datapath between NREQ requesters.
- A round-robin arbiter picks one pending request and latches its 8-bit operand. A three-state FSM then evaluates the reduction, returns the result and pulses a per-requester done.
- Sits between client blocks and the shared reduction resource, so one requester can never starve another.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, 2, width of the granted-requester index; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NREQ  level request per requester; bit i belongs to requester i.
- data  input  8*NREQ  operands; requester i drives bits [8*i+7 : 8*i].
- gnt  output  NREQ  one-hot grant; bit of the owning requester is high from the grant edge until the owner leaves RESP.
- done  output  NREQ  one-cycle pulse to the owner while the result is valid.
- out  output  1  AND of all 8 bits of the latched operand; holds its last value between operations.
- out_id  output  IDW  index of the requester that owns out.
- busy  output  1  high in EVAL and RESP.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, ptr=0, opnd=0, id=0; gnt=0, done=0, out=0, out_id=0, busy=0. Reset has priority over every other event.
- Reset mid-operation: the operation is aborted, no done is issued and the pointer returns to 0.
- Arbitration: in IDLE, scan req starting at index ptr and increasing modulo NREQ; the first set bit wins.
- Grant edge: at the edge where IDLE sees any req set, latch opnd from the winner's data slice, set id to the winner, set gnt to onehot(winner), busy=1, and move to EVAL.
- Late requests: requests arriving during EVAL or RESP wait; they are not queued beyond the req level itself.
- EVAL (1 cycle): at the next edge, out = AND of opnd[7:0], out_id = id, done = onehot(id), move to RESP.
- RESP (1 cycle): done and gnt stay asserted for this cycle. At the next edge:
  - ptr = (id+1) mod NREQ
  - done = 0, gnt = 0, busy = 0
  - move to IDLE
- Latency: req seen at edge k gives gnt visible after edge k, done and out visible after edge k+1, and IDLE again after edge k+2. Fixed throughput is one operation per 3 cycles under continuous load.
- Operand stability: data is sampled only at the grant edge. Later changes on data do not affect the operation in flight.
- Request drop: clearing req after the grant does not abort the operation; done is still pulsed.
- Request held high after done: the requester is re-eligible, but ptr has moved past it, so other pending requesters win first.
- Simultaneous requests: at most one grant per IDLE cycle; gnt is never multi-hot.
- done and gnt: both are 0 for every requester other than id.
- Pointer wrap: when id = NREQ-1, ptr becomes 0.
- Idle with no req: state holds, all outputs hold; out and out_id retain the last result.

Test Plan:
- Reset with all inputs active: assert rst_n=0 mid-EVAL with req=4'b0001 and data0=8'hFF -> gnt, done, busy and out all go to 0 immediately; after release, the next grant goes to requester 0 with no stale done pulse.
- Single request: req=4'b0100, data2=8'hFF -> gnt=4'b0100 after the first edge; done=4'b0100, out=1 and out_id=2 after the second edge; busy falls after the third edge.
- Zero-bit operand: req=4'b0001, data0=8'hFE -> out=0, out_id=0, done[0] pulses for exactly 1 cycle.
- Round-robin fairness: req=4'b1111 held continuously, all operands 8'hFF -> grant order 0,1,2,3,0; exactly one done per 3 cycles; gnt always one-hot.
- Pointer wrap and skip: ptr=3 (after serving requester 2), req=4'b0011 -> requester 0 wins, then requester 1.
- Operand and request changes mid-operation: after the grant to requester 1 (data1=8'hFF), change data1 to 8'h00 and drop req[1] during EVAL -> out=1, done[1] still pulses, and no new grant appears until IDLE.
